// File: rtl/result_sig_capture_pkg.sv
// Shared types and helpers for the result signature capture stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package result_sig_capture_pkg;

  localparam int          SIG_W    = 32;
  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;

  typedef logic [SIG_W-1:0] sig_t;
  typedef logic [15:0]      cnt_t;

  // XOR of the four 32-bit words of a 128-bit result vector.
  function automatic sig_t fold_words(input logic [127:0] d);
    return d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
  endfunction

  // One signature step: shift left, apply feedback on MSB, mix in word.
  function automatic sig_t sig_step(input sig_t s, input sig_t word, input sig_t poly);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? poly : '0) ^ word;
  endfunction

endpackage

// File: rtl/result_sig_fifo.sv
// Flop-array FIFO with occupancy counter, full/empty and synchronous flush.
// Latency: one cycle from push to head; no bypass.
// Backpressure: full blocks push; pop on empty is ignored; flush discards both.
module result_sig_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full     = (occ == (AW+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign do_push  = push && !flush && !full;
  assign do_pop   = pop && !flush && !empty;
  // Head reads as zero when empty so the output is clean after reset/flush.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents are only observed through non-empty head reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_sig_capture.sv
// Buffers result vectors and folds each accepted one into a 32-bit signature.
// Latency: accepted in cycle N, visible at out_data in cycle N+1.
// Backpressure: in_ready = !full && !flush; independent of same-cycle out_ready.
// Optional X/Z checking on accepted data is enabled by RESULT_SIG_CAPTURE_XCHK_EN.
module result_sig_capture
  import result_sig_capture_pkg::*;
#(
  parameter int          WIDTH     = 128,
  parameter int          DEPTH     = 4,
  parameter int          USED_BITS = 16,
  parameter logic [31:0] POLY      = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      sig,
  output logic [15:0]      count,
  output logic             hi_err,
  output logic             x_seen
);

  logic full;
  logic empty;
  logic push;
  logic pop;
  sig_t fold_w;

  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  result_sig_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty)
  );

  // Width-generic fold: XOR of every 32-bit word of the incoming vector.
  always_comb begin
    fold_w = '0;
    for (int i = 0; i < WIDTH/32; i++) begin
      fold_w = fold_w ^ in_data[i*32 +: 32];
    end
  end

  // Signature, saturating count and sticky high-bit flag advance only on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig    <= '0;
      count  <= '0;
      hi_err <= 1'b0;
    end else if (flush) begin
      sig    <= '0;
      count  <= '0;
      hi_err <= 1'b0;
    end else if (push) begin
      sig    <= sig_step(sig, fold_w, POLY);
      if (count != 16'hFFFF) count <= count + 1'b1;
      hi_err <= hi_err | (|in_data[WIDTH-1:USED_BITS]);
    end
  end

`ifdef RESULT_SIG_CAPTURE_XCHK_EN
  logic [31:0] cyc_cnt;
  logic        x_seen_q;

  assign x_seen = x_seen_q;

  // Simulation-only X/Z detector on accepted vectors; sig still uses raw data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      x_seen_q <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (flush) begin
        x_seen_q <= 1'b0;
      end else if (push && ((^in_data) === 1'bx)) begin
        x_seen_q <= 1'b1;
        $error("result_sig_capture: X/Z on accepted vector, cycle %0d data %h", cyc_cnt, in_data);
      end
    end
  end
`else
  assign x_seen = 1'b0;
`endif

endmodule

// File: tb/tb_result_sig_capture.sv
// Scoreboard bench for result_sig_capture: expected data queued on accept, compared at head.
// Latency: model tracks one-cycle push-to-head behaviour.
// Backpressure: model derives in_ready from its own occupancy.
module tb_result_sig_capture;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
`ifdef RESULT_SIG_CAPTURE_XCHK_EN
  localparam bit XEN = 1'b1;
`else
  localparam bit XEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [31:0]  sig;
  logic [15:0]  count;
  logic         hi_err;
  logic         x_seen;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] sb [$];
  logic [31:0]  m_sig = '0;
  logic [15:0]  m_cnt = '0;
  logic         m_hi  = 1'b0;
  logic         m_x   = 1'b0;

  result_sig_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sig       (sig),
    .count     (count),
    .hi_err    (hi_err),
    .x_seen    (x_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mfold(input logic [127:0] d);
    return d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
  endfunction

  task automatic model_clear();
    sb.delete();
    m_sig = '0;
    m_cnt = '0;
    m_hi  = 1'b0;
    m_x   = 1'b0;
  endtask

  // One clock: drive at negedge, check pre-edge outputs, step the model, return after posedge.
  task automatic cyc(input logic v, input logic [127:0] d, input logic ordy, input logic fl);
    logic do_push;
    logic do_pop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("in_ready",  in_ready,  !fl && (sb.size() < 4));
    check("out_valid", out_valid, sb.size() > 0);
    check("out_data",  out_data,  (sb.size() > 0) ? sb[0] : 128'h0);
    check("sig",       sig,       m_sig);
    check("count",     count,     m_cnt);
    check("hi_err",    hi_err,    m_hi);
    check("x_seen",    x_seen,    m_x);
    if (fl) begin
      model_clear();
    end else begin
      do_pop  = (sb.size() > 0) && ordy;
      do_push = v && (sb.size() < 4);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(d);
        m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? POLY : 32'h0) ^ mfold(d);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_hi = m_hi | (|d[127:16]);
        m_x  = m_x | (XEN && ((^d) === 1'bx));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] xd;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Mid-run asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 128'hA0 + 128'(i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sig",       sig,       32'h0);
    check("rst_count",     count,     16'h0);
    check("rst_in_ready",  in_ready,  1'b1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Two pushes of 128'h1 while the consumer stalls.
    cyc(1'b1, 128'h1, 1'b0, 1'b0);
    check("t2_sig1", sig, 32'h1);
    check("t2_head", out_data, 128'h1);
    cyc(1'b1, 128'h1, 1'b0, 1'b0);
    check("t2_sig2",  sig,   32'h3);
    check("t2_count", count, 16'd2);

    // Vector whose words cancel: only the shift/feedback term moves sig.
    cyc(1'b1, 128'h0000_0001_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
    check("t3_sig",   sig,   32'h6);
    check("t3_count", count, 16'd3);

    // Fill to full, attempt an extra push, pop once, then drain with mixed traffic.
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, {4{32'h1000_0000 + 32'(i)}}, 1'b0, 1'b0);
    check("t4_full_rdy", in_ready, 1'b0);
    cyc(1'b1, 128'hDEAD, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("t4_pop_rdy", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'(i % 2), 128'h5000 + 128'(i), 1'b1, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 128'h77, 1'b1, 1'b0);
    check("t4_empty_pushpop", out_valid, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Bit at USED_BITS sets the sticky flag; flush with valid pushes nothing.
    cyc(1'b1, 128'h1_0000, 1'b0, 1'b0);
    check("t5_hi_set", hi_err, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    check("t5_hi_hold", hi_err, 1'b1);
    cyc(1'b1, 128'h9, 1'b0, 1'b1);
    check("t5_flush_count", count,     16'd0);
    check("t5_flush_hi",    hi_err,    1'b0);
    check("t5_flush_vld",   out_valid, 1'b0);

    // Unknown bit on an accepted vector.
    xd    = '0;
    xd[3] = 1'bx;
    cyc(1'b1, xd, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("t6_x_seen", x_seen, m_x);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
